// File: rtl/jtag_link_pkg.sv
// Shared types, register map constants and chunk-count helpers for the JTAG-UART sample link.
package jtag_link_pkg;

    typedef enum logic [2:0] {
        RX_READ,
        ARM,
        CAPTURE,
        TX_POLL,
        TX_WRITE
    } link_state_e;

    localparam logic ADDR_DATA = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    localparam int unsigned RVALID_BIT = 15;
    localparam int unsigned WSPACE_MSB = 31;
    localparam int unsigned WSPACE_LSB = 16;

    localparam logic       TAG_FINAL_RX = 1'b1;
    localparam logic [2:0] TAG_FINAL_TX = 3'b111;
    localparam logic [2:0] TAG_MID_TX   = 3'b000;

    localparam int unsigned RX_PAYLOAD_W = 6;
    localparam int unsigned TX_PAYLOAD_W = 5;

    // Number of 6-bit host chunks needed for a DAC code.
    function automatic int unsigned nrx(input int unsigned dac_w);
        return (dac_w + RX_PAYLOAD_W - 1) / RX_PAYLOAD_W;
    endfunction

    // Number of 5-bit return chunks needed for an ADC sample.
    function automatic int unsigned ntx(input int unsigned adc_w);
        return (adc_w + TX_PAYLOAD_W - 1) / TX_PAYLOAD_W;
    endfunction

endpackage

// File: rtl/sample_buffer.sv
// Simple dual-port sample store: one write port, registered read with 1-cycle latency.
module sample_buffer #(
    parameter int unsigned Depth = 128,
    parameter int unsigned Width = 10
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdata_q;

    // Write port and registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jtag_sample_link.sv
// JTAG-UART bridge: receives chunked DAC codes, captures DEPTH ADC samples, streams them back.
module jtag_sample_link
    import jtag_link_pkg::*;
#(
    parameter int unsigned DAC_W = 12,
    parameter int unsigned ADC_W = 10,
    parameter int unsigned DEPTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    output logic             avm_address,
    output logic             avm_read,
    output logic             avm_write,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_waitrequest,
    output logic [DAC_W-1:0] dac_value,
    output logic             dac_push,
    output logic             start_sampling,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] sample_data,
    output logic             busy,
    output logic             err_framing
);

    localparam int unsigned NRX       = nrx(DAC_W);
    localparam int unsigned NTX       = ntx(ADC_W);
    localparam int unsigned RX_IDX_W  = (NRX > 1) ? $clog2(NRX) : 1;
    localparam int unsigned TX_IDX_W  = (NTX > 1) ? $clog2(NTX) : 1;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned RX_WORD_W = NRX * RX_PAYLOAD_W;
    localparam int unsigned TX_WORD_W = NTX * TX_PAYLOAD_W;

    localparam logic [RX_IDX_W-1:0] RX_LAST     = RX_IDX_W'(NRX - 1);
    localparam logic [TX_IDX_W-1:0] TX_LAST     = TX_IDX_W'(NTX - 1);
    localparam logic [PTR_W-1:0]    PTR_LAST    = PTR_W'(DEPTH - 1);
    localparam logic [15:0]         WSPACE_NEED = 16'(NTX);

    link_state_e state_q, state_d;

    logic [RX_IDX_W-1:0]  rx_idx_q, rx_idx_d;
    logic [RX_WORD_W-1:0] rx_word_q, rx_word_d;
    logic [TX_IDX_W-1:0]  tx_idx_q, tx_idx_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DAC_W-1:0]     dac_value_q, dac_value_d;
    logic                 dac_push_q, dac_push_d;
    logic                 start_q, start_d;
    logic                 err_q, err_d;
    logic                 avm_read_q, avm_read_d;
    logic                 avm_write_q, avm_write_d;
    logic                 avm_address_q, avm_address_d;
    logic [31:0]          avm_writedata_q, avm_writedata_d;

    logic                 buf_we;
    logic [ADC_W-1:0]     buf_rdata;
    logic                 read_done;
    logic                 write_done;
    logic [7:0]           rx_byte;
    logic [RX_WORD_W-1:0] rx_word_tmp;
    logic                 unused_rdata;

    assign unused_rdata = ^avm_readdata[14:8];

    // Build one outgoing byte: 5 payload bits of the sample, tagged final or mid.
    function automatic logic [31:0] tx_chunk(input logic [ADC_W-1:0]    s,
                                             input logic [TX_IDX_W-1:0] idx);
        logic [TX_WORD_W-1:0]    w;
        logic [TX_PAYLOAD_W-1:0] p;
        w = TX_WORD_W'(s);
        p = w[idx*TX_PAYLOAD_W +: TX_PAYLOAD_W];
        return {24'h0, (idx == TX_LAST) ? TAG_FINAL_TX : TAG_MID_TX, p};
    endfunction

    sample_buffer #(
        .Depth (DEPTH),
        .Width (ADC_W)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (buf_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (sample_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (buf_rdata)
    );

    // State and output registers; synchronous reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= RX_READ;
            rx_idx_q        <= '0;
            rx_word_q       <= '0;
            tx_idx_q        <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            dac_value_q     <= '0;
            dac_push_q      <= 1'b0;
            start_q         <= 1'b0;
            err_q           <= 1'b0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            avm_address_q   <= 1'b0;
            avm_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            rx_idx_q        <= rx_idx_d;
            rx_word_q       <= rx_word_d;
            tx_idx_q        <= tx_idx_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            dac_value_q     <= dac_value_d;
            dac_push_q      <= dac_push_d;
            start_q         <= start_d;
            err_q           <= err_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
        end
    end

    // Next-state logic; bus strobes are held until a cycle without waitrequest.
    always_comb begin
        state_d         = state_q;
        rx_idx_d        = rx_idx_q;
        rx_word_d       = rx_word_q;
        tx_idx_d        = tx_idx_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        dac_value_d     = dac_value_q;
        dac_push_d      = 1'b0;
        start_d         = start_q;
        err_d           = err_q;
        avm_read_d      = avm_read_q;
        avm_write_d     = avm_write_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        buf_we          = 1'b0;

        read_done   = avm_read_q & ~avm_waitrequest;
        write_done  = avm_write_q & ~avm_waitrequest;
        rx_byte     = avm_readdata[7:0];
        rx_word_tmp = rx_word_q;
        rx_word_tmp[rx_idx_q*RX_PAYLOAD_W +: RX_PAYLOAD_W] = rx_byte[5:0];

        unique case (state_q)
            RX_READ: begin
                avm_read_d    = 1'b1;
                avm_address_d = ADDR_DATA;
                if (read_done && avm_readdata[RVALID_BIT]) begin
                    if (rx_byte[7] == TAG_FINAL_RX && rx_idx_q == RX_LAST) begin
                        dac_value_d = rx_word_tmp[DAC_W-1:0];
                        dac_push_d  = 1'b1;
                        avm_read_d  = 1'b0;
                        rx_idx_d    = '0;
                        rx_word_d   = '0;
                        state_d     = ARM;
                    end else if (rx_byte[7] == TAG_FINAL_RX || rx_idx_q == RX_LAST) begin
                        // Early final or one chunk too many: drop the partial word.
                        err_d     = 1'b1;
                        rx_idx_d  = '0;
                        rx_word_d = '0;
                    end else begin
                        rx_word_d = rx_word_tmp;
                        rx_idx_d  = rx_idx_q + 1'b1;
                    end
                end
            end
            ARM: begin
                start_d  = 1'b1;
                wr_ptr_d = '0;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                if (sample_valid) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == PTR_LAST) begin
                        start_d = 1'b0;
                        state_d = TX_POLL;
                    end
                end
            end
            TX_POLL: begin
                // buf[rd_ptr] is prefetched here; the poll read is issued a cycle after entry.
                avm_read_d    = 1'b1;
                avm_address_d = ADDR_CTRL;
                if (read_done && avm_readdata[WSPACE_MSB:WSPACE_LSB] >= WSPACE_NEED) begin
                    avm_read_d      = 1'b0;
                    avm_write_d     = 1'b1;
                    avm_address_d   = ADDR_DATA;
                    tx_idx_d        = '0;
                    avm_writedata_d = tx_chunk(buf_rdata, '0);
                    state_d         = TX_WRITE;
                end
            end
            TX_WRITE: begin
                if (write_done) begin
                    if (tx_idx_q == TX_LAST) begin
                        avm_write_d     = 1'b0;
                        avm_writedata_d = '0;
                        rd_ptr_d        = rd_ptr_q + 1'b1;
                        state_d         = (rd_ptr_q == PTR_LAST) ? RX_READ : TX_POLL;
                    end else begin
                        tx_idx_d        = tx_idx_q + 1'b1;
                        avm_writedata_d = tx_chunk(buf_rdata, tx_idx_q + 1'b1);
                    end
                end
            end
            default: begin
                state_d = RX_READ;
            end
        endcase
    end

    assign avm_address    = avm_address_q;
    assign avm_read       = avm_read_q;
    assign avm_write      = avm_write_q;
    assign avm_writedata  = avm_writedata_q;
    assign dac_value      = dac_value_q;
    assign dac_push       = dac_push_q;
    assign start_sampling = start_q;
    assign busy           = (state_q != RX_READ);
    assign err_framing    = err_q;

endmodule

// File: tb/tb_jtag_sample_link.sv
// Directed bench for jtag_sample_link: bus slave model, sample feeder and byte scoreboard.
module tb_jtag_sample_link;

    localparam int DAC_W = 12;
    localparam int ADC_W = 10;
    localparam int DEPTH = 128;

    logic             clk = 1'b0;
    logic             reset;
    logic             avm_address;
    logic             avm_read;
    logic             avm_write;
    logic [31:0]      avm_writedata;
    logic [31:0]      avm_readdata;
    logic             avm_waitrequest;
    logic [DAC_W-1:0] dac_value;
    logic             dac_push;
    logic             start_sampling;
    logic             sample_valid;
    logic [ADC_W-1:0] sample_data;
    logic             busy;
    logic             err_framing;

    int n_checks = 0;
    int n_errors = 0;
    int push_cnt = 0;
    int r;

    logic [ADC_W-1:0] exp_s [DEPTH];
    logic [31:0]      got_q [$];

    jtag_sample_link #(
        .DAC_W (DAC_W),
        .ADC_W (ADC_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .dac_value       (dac_value),
        .dac_push        (dac_push),
        .start_sampling  (start_sampling),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .busy            (busy),
        .err_framing     (err_framing)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (dac_push) push_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Deliver one host byte; the first n_invalid reads return RVALID=0 with junk data.
    task automatic send_rx(input logic [7:0] b, input int n_invalid, output int reads);
        int cyc;
        cyc   = 0;
        reads = 0;
        avm_waitrequest = 1'b0;
        while (1) begin
            if (cyc > 200) begin
                check("rx_timeout", 32'(reads), 32'(n_invalid + 1));
                return;
            end
            if (avm_read && avm_address == 1'b0 && !avm_write) begin
                reads++;
                if (reads > n_invalid) begin
                    avm_readdata = 32'h0000_8000 | 32'(b);
                    step();
                    avm_readdata = 32'h0;
                    return;
                end
                avm_readdata = 32'h0000_00BF;
            end else begin
                avm_readdata = 32'h0;
            end
            step();
            cyc++;
        end
    endtask

    // Entered in ARM; a stray sample during ARM must not be stored.
    task automatic capture(input int n);
        sample_valid = 1'b1;
        sample_data  = 10'h2AA;
        step();
        check("start_in_capture", 32'(start_sampling), 32'd1);
        check("push_one_cycle", 32'(dac_push), 32'd0);
        for (int i = 0; i < n; i++) begin
            if (i % 16 == 15) begin
                sample_valid = 1'b0;
                step();
            end
            sample_valid = 1'b1;
            sample_data  = exp_s[i];
            step();
        end
        sample_valid = 1'b0;
        if (n == DEPTH) check("start_drop", 32'(start_sampling), 32'd0);
    endtask

    // Slave model for the return stream; stray samples are offered throughout.
    task automatic run_tx(input int low_polls, input bit rand_wait, input int n_bytes,
                          input bit expect_done);
        int          polls;
        int          early;
        int          unstable;
        int          overlap;
        bit          pend;
        logic [31:0] pend_data;
        logic [31:0] e;
        logic [ADC_W-1:0] s;
        polls = 0; early = 0; unstable = 0; overlap = 0; pend = 1'b0; pend_data = '0;
        got_q.delete();
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (pend && !(avm_write && avm_address == 1'b0 && avm_writedata == pend_data))
                unstable++;
            pend = 1'b0;
            if (avm_read && avm_write) overlap++;
            sample_valid    = 1'b1;
            sample_data     = ADC_W'($urandom_range(0, 1023));
            avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
            avm_readdata    = 32'h0;
            if (avm_read && avm_address == 1'b1) begin
                avm_readdata = {(polls < low_polls) ? 16'd1 : 16'd64, 16'h0};
                if (!avm_waitrequest) polls++;
            end else if (avm_write) begin
                if (!avm_waitrequest) begin
                    got_q.push_back(avm_writedata);
                    if (polls <= low_polls) early++;
                end else begin
                    pend      = 1'b1;
                    pend_data = avm_writedata;
                end
            end
            step();
            if (got_q.size() == n_bytes) break;
        end
        sample_valid    = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h0;
        check("tx_count", 32'(got_q.size()), 32'(n_bytes));
        check("write_before_space", 32'(early), 32'd0);
        check("stall_stable", 32'(unstable), 32'd0);
        check("rd_wr_overlap", 32'(overlap), 32'd0);
        for (int k = 0; k < got_q.size(); k++) begin
            s = exp_s[k / 2];
            e = (k % 2 == 0) ? {24'h0, 3'b000, s[4:0]} : {24'h0, 3'b111, s[9:5]};
            check($sformatf("tx_byte%0d", k), got_q[k], e);
        end
        if (expect_done) begin
            check("tx_done_idle", 32'(busy), 32'd0);
            check("tx_done_nowrite", 32'(avm_write), 32'd0);
        end else begin
            check("tx_mid_write", 32'(avm_write), 32'd1);
        end
    endtask

    // Reset for one cycle, check every output is cleared, then the link resumes reading.
    task automatic check_reset_state(input string tag);
        reset           = 1'b1;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h0;
        sample_valid    = 1'b0;
        step();
        check({tag, "_read"}, 32'(avm_read), 32'd0);
        check({tag, "_write"}, 32'(avm_write), 32'd0);
        check({tag, "_addr"}, 32'(avm_address), 32'd0);
        check({tag, "_wdata"}, avm_writedata, 32'd0);
        check({tag, "_dac"}, 32'(dac_value), 32'd0);
        check({tag, "_push"}, 32'(dac_push), 32'd0);
        check({tag, "_start"}, 32'(start_sampling), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err_framing), 32'd0);
        reset = 1'b0;
        step();
        check({tag, "_resume"}, 32'(avm_read), 32'd1);
    endtask

    initial begin
        reset           = 1'b1;
        avm_readdata    = 32'h0;
        avm_waitrequest = 1'b0;
        sample_valid    = 1'b0;
        sample_data     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_read", 32'(avm_read), 32'd0);
        check("rst_dac", 32'(dac_value), 32'd0);
        check("rst_err", 32'(err_framing), 32'd0);
        reset = 1'b0;
        step();
        check("first_read", 32'(avm_read), 32'd1);

        // Run 1: framing error, RVALID stalls, commit, full capture and return.
        send_rx(8'h81, 0, r);
        check("err_final_first", 32'(err_framing), 32'd1);
        check("err_stays_rx", 32'(busy), 32'd0);
        send_rx(8'h15, 5, r);
        check("rvalid_reads", 32'(r), 32'd6);
        check("no_early_commit", 32'(busy), 32'd0);
        send_rx(8'hAA, 0, r);
        check("commit_push", 32'(dac_push), 32'd1);
        check("commit_value", 32'(dac_value), 32'hA95);
        check("commit_busy", 32'(busy), 32'd1);
        for (int i = 0; i < DEPTH; i++) exp_s[i] = (i == 5) ? 10'h3FF : ADC_W'(i);
        capture(DEPTH);
        run_tx(0, 1'b0, 2 * DEPTH, 1'b1);
        check("push_total1", 32'(push_cnt), 32'd1);
        check("dac_hold", 32'(dac_value), 32'hA95);

        // Run 2: low WSPACE for 20 polls, random stalls.
        send_rx(8'h3F, 0, r);
        send_rx(8'h80, 0, r);
        check("commit2_value", 32'(dac_value), 32'h03F);
        for (int i = 0; i < DEPTH; i++) exp_s[i] = ADC_W'((i * 37 + 3) & 32'h3FF);
        capture(DEPTH);
        run_tx(20, 1'b1, 2 * DEPTH, 1'b1);
        check("push_total2", 32'(push_cnt), 32'd2);

        // Run 3: reset during capture.
        send_rx(8'h01, 0, r);
        send_rx(8'h80, 0, r);
        check("commit3_value", 32'(dac_value), 32'h001);
        capture(10);
        check_reset_state("rst_cap");

        // Run 4: surplus non-final chunk, then reset during a write.
        send_rx(8'h01, 0, r);
        send_rx(8'h02, 0, r);
        check("err_extra_chunk", 32'(err_framing), 32'd1);
        check("err_no_commit", 32'(busy), 32'd0);
        send_rx(8'h15, 0, r);
        send_rx(8'hAA, 0, r);
        check("commit4_value", 32'(dac_value), 32'hA95);
        for (int i = 0; i < DEPTH; i++) exp_s[i] = ADC_W'(1023 - i);
        capture(DEPTH);
        run_tx(0, 1'b0, 3, 1'b0);
        check_reset_state("rst_tx");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
